handshake_const_sink: RTL and testbench

- Terminal receiver for a valid/ready data channel, such as the output of a constant-generator node.
- Accepts a batch of NUM_TOKENS data tokens and checks each one against a parameterised expected value.
- Records the last value received and a per-batch mismatch flag.
- Issues a single control "done" token downstream when the batch completes; used as the consuming end of constant-driven dataflow paths and as an in-circuit self-check point.

---
 rtl/handshake_const_sink.sv | 82 ++++++++
 tb/tb_handshake_const_sink.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_const_sink.sv
// Terminal valid/ready sink: counts a batch of NUM_TOKENS tokens, checks each
// against EXPECTED, and emits one done token carrying a sticky mismatch flag.
module handshake_const_sink #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] EXPECTED    = '0,
  parameter int                    NUM_TOKENS  = 4,
  parameter int                    COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  ins,
  input  logic                   ins_valid,
  output logic                   ins_ready,
  output logic                   done_valid,
  input  logic                   done_ready,
  output logic                   done_mismatch,
  output logic [COUNT_WIDTH-1:0] count,
  output logic [DATA_WIDTH-1:0]  last_value
);

  typedef enum logic {RECV, DONE} state_t;

  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(NUM_TOKENS - 1);
  localparam logic [COUNT_WIDTH-1:0] ONE        = COUNT_WIDTH'(1);

  state_t                 state_reg;
  logic                   ins_ready_reg;
  logic                   done_valid_reg;
  logic                   mismatch_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic [DATA_WIDTH-1:0]  last_value_reg;

  // Handshake outputs are registered alongside the state so neither ready nor
  // valid has a combinational path from the opposite side of the channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RECV;
      ins_ready_reg  <= 1'b1;
      done_valid_reg <= 1'b0;
      mismatch_reg   <= 1'b0;
      count_reg      <= '0;
      last_value_reg <= '0;
    end else begin
      case (state_reg)
        RECV: begin
          if (ins_valid && ins_ready_reg) begin
            last_value_reg <= ins;
            count_reg      <= count_reg + ONE;
            if (ins != EXPECTED) mismatch_reg <= 1'b1;
            if (count_reg == LAST_COUNT) begin
              state_reg      <= DONE;
              ins_ready_reg  <= 1'b0;
              done_valid_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          // last_value survives the handshake; only batch state is cleared.
          if (done_valid_reg && done_ready) begin
            state_reg      <= RECV;
            ins_ready_reg  <= 1'b1;
            done_valid_reg <= 1'b0;
            mismatch_reg   <= 1'b0;
            count_reg      <= '0;
          end
        end
        default: begin
          state_reg      <= RECV;
          ins_ready_reg  <= 1'b1;
          done_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign ins_ready     = ins_ready_reg;
  assign done_valid    = done_valid_reg;
  assign done_mismatch = mismatch_reg;
  assign count         = count_reg;
  assign last_value    = last_value_reg;

endmodule

// File: tb/tb_handshake_const_sink.sv
// Bench for handshake_const_sink: a 4-token and a 1-token instance share one
// stimulus stream; each is predicted by a queue holding the open batch.
module tb_handshake_const_sink;

  localparam int          DW  = 34;
  localparam logic [33:0] EXP = 34'h150348F47;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] ins = '0;
  logic          ins_valid = 1'b0;
  logic          done_ready = 1'b0;

  logic          ins_ready4, done_valid4, done_mismatch4;
  logic [7:0]    count4;
  logic [DW-1:0] last_value4;
  logic          ins_ready1, done_valid1, done_mismatch1;
  logic [7:0]    count1;
  logic [DW-1:0] last_value1;

  int checks = 0;
  int errors = 0;

  // Open batch contents and last accepted token for each instance.
  logic [DW-1:0] q4[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] last4 = '0;
  logic [DW-1:0] last1 = '0;

  always #5 clk = ~clk;

  handshake_const_sink #(.DATA_WIDTH(DW), .EXPECTED(EXP), .NUM_TOKENS(4), .COUNT_WIDTH(8)) dut4 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready4),
    .done_valid(done_valid4), .done_ready(done_ready), .done_mismatch(done_mismatch4),
    .count(count4), .last_value(last_value4)
  );

  handshake_const_sink #(.DATA_WIDTH(DW), .EXPECTED(EXP), .NUM_TOKENS(1), .COUNT_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready1),
    .done_valid(done_valid1), .done_ready(done_ready), .done_mismatch(done_mismatch1),
    .count(count1), .last_value(last_value1)
  );

  function automatic bit any_mis(input logic [DW-1:0] q[$]);
    foreach (q[i]) if (q[i] != EXP) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle of inputs, advance the models at the edge, settle 1 time unit.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic dr, input logic r);
    ins_valid = v; ins = d; done_ready = dr; rst = r;
    @(posedge clk);
    if (r) begin
      q4.delete(); last4 = '0;
      q1.delete(); last1 = '0;
    end else begin
      if (q4.size() == 4) begin
        if (dr) q4.delete();
      end else if (v) begin
        q4.push_back(d); last4 = d;
      end
      if (q1.size() == 1) begin
        if (dr) q1.delete();
      end else if (v) begin
        q1.push_back(d); last1 = d;
      end
    end
    #1;
    $display("txn t=%0t rst=%0b v=%0b d=%h dr=%0b | n4: cnt=%0d rdy=%0b dv=%0b mm=%0b | n1: cnt=%0d dv=%0b",
             $time, r, v, d, dr, count4, ins_ready4, done_valid4, done_mismatch4, count1, done_valid1);
  endtask

  task automatic test_reset();
    step(1'b1, EXP, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (count4 !== 8'd0 || ins_ready4 !== 1'b1 || done_valid4 !== 1'b0 ||
        done_mismatch4 !== 1'b0 || last_value4 !== '0) begin
      errors++;
      $display("FAIL reset4 got cnt=%0d rdy=%0b dv=%0b mm=%0b last=%h want 0/1/0/0/0",
               count4, ins_ready4, done_valid4, done_mismatch4, last_value4);
    end
    checks++;
    if (count1 !== 8'd0 || ins_ready1 !== 1'b1 || done_valid1 !== 1'b0 ||
        done_mismatch1 !== 1'b0 || last_value1 !== '0) begin
      errors++;
      $display("FAIL reset1 got cnt=%0d rdy=%0b dv=%0b mm=%0b last=%h want 0/1/0/0/0",
               count1, ins_ready1, done_valid1, done_mismatch1, last_value1);
    end
  endtask

  // Feeds `toks` back to back and then idles, comparing n4 against the model.
  task automatic run_batch(input string name, input logic [DW-1:0] toks[4], input int idle);
    for (int i = 0; i < 4 + idle; i++) begin
      if (i < 4) step(1'b1, toks[i], 1'b1, 1'b0);
      else       step(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (count4 !== 8'(q4.size()) || ins_ready4 !== (q4.size() != 4) ||
          done_valid4 !== (q4.size() == 4) || last_value4 !== last4) begin
        errors++;
        $display("FAIL %s cyc%0d got cnt=%0d rdy=%0b dv=%0b last=%h want %0d/%0b/%0b/%h",
                 name, i, count4, ins_ready4, done_valid4, last_value4,
                 q4.size(), q4.size() != 4, q4.size() == 4, last4);
      end
      if (q4.size() == 4) begin
        checks++;
        if (done_mismatch4 !== any_mis(q4)) begin
          errors++;
          $display("FAIL %s_mismatch got %0b want %0b", name, done_mismatch4, any_mis(q4));
        end
      end
    end
  endtask

  task automatic test_clean_batch();
    logic [DW-1:0] t[4];
    t = '{EXP, EXP, EXP, EXP};
    step(1'b0, '0, 1'b1, 1'b1);
    run_batch("clean", t, 2);
  endtask

  task automatic test_mismatch_batch();
    logic [DW-1:0] t[4];
    t = '{EXP, EXP, 34'h150348F46, EXP};
    step(1'b0, '0, 1'b1, 1'b1);
    run_batch("mism", t, 1);
    t = '{EXP, EXP, EXP, EXP};
    run_batch("after_mism", t, 1);
  endtask

  task automatic test_done_stall();
    logic [DW-1:0] held;
    held = 34'h0DEADBEEF;
    step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, EXP, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, held, 1'b0, 1'b0);
      checks++;
      if (done_valid4 !== 1'b1 || ins_ready4 !== 1'b0 || count4 !== 8'd4 || last_value4 !== EXP) begin
        errors++;
        $display("FAIL stall cyc%0d got dv=%0b rdy=%0b cnt=%0d last=%h want 1/0/4/%h",
                 i, done_valid4, ins_ready4, count4, last_value4, EXP);
      end
    end
    step(1'b1, held, 1'b1, 1'b0);
    step(1'b1, held, 1'b1, 1'b0);
    checks++;
    if (count4 !== 8'd1 || last_value4 !== held || count4 !== 8'(q4.size())) begin
      errors++;
      $display("FAIL stall_release got cnt=%0d last=%h want 1/%h", count4, last_value4, held);
    end
  endtask

  task automatic test_single_token();
    int dones = 0;
    step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, EXP ^ 34'(i), 1'b1, 1'b0);
      dones += int'(done_valid1);
      checks++;
      if (done_valid1 !== (i % 2 == 0) || ins_ready1 !== (i % 2 != 0) ||
          done_valid1 !== (q1.size() == 1)) begin
        errors++;
        $display("FAIL single cyc%0d got dv=%0b rdy=%0b want %0b/%0b",
                 i, done_valid1, ins_ready1, i % 2 == 0, i % 2 != 0);
      end
      if (done_valid1 === 1'b1) begin
        checks++;
        if (done_mismatch1 !== any_mis(q1) || last_value1 !== last1) begin
          errors++;
          $display("FAIL single_tok cyc%0d got mm=%0b last=%h want %0b/%h",
                   i, done_mismatch1, last_value1, any_mis(q1), last1);
        end
      end
    end
    checks++;
    if (dones != 5) begin
      errors++;
      $display("FAIL single_count got %0d dones want 5", dones);
    end
  endtask

  task automatic test_reset_mid_batch();
    logic [DW-1:0] t[4];
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 34'h000000001, 1'b1, 1'b0);
    step(1'b1, EXP, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (count4 !== 8'd0 || done_mismatch4 !== 1'b0 || last_value4 !== '0 || ins_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got cnt=%0d mm=%0b last=%h rdy=%0b want 0/0/0/1",
               count4, done_mismatch4, last_value4, ins_ready4);
    end
    t = '{EXP, EXP, EXP, EXP};
    run_batch("post_reset", t, 1);
  endtask

  task automatic test_reset_in_done();
    step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, EXP + 34'(i), 1'b0, 1'b0);
    checks++;
    if (done_valid4 !== 1'b1 || done_mismatch4 !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_done got dv=%0b mm=%0b want 1/1", done_valid4, done_mismatch4);
    end
    step(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (count4 !== 8'd0 || done_valid4 !== 1'b0 || ins_ready4 !== 1'b1 || last_value4 !== '0) begin
      errors++;
      $display("FAIL rst_in_done got cnt=%0d dv=%0b rdy=%0b last=%h want 0/0/1/0",
               count4, done_valid4, ins_ready4, last_value4);
    end
  endtask

  task automatic test_random();
    logic          v, dr, r;
    logic [DW-1:0] d;
    step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 2) != 0);
      r  = ($urandom_range(0, 40) == 0);
      d  = ($urandom_range(0, 3) == 0) ? {$urandom(), $urandom()} : EXP;
      step(v, d, dr, r);
      checks++;
      if (count4 !== 8'(q4.size()) || done_valid4 !== (q4.size() == 4) ||
          ins_ready4 !== (q4.size() != 4) || last_value4 !== last4 ||
          (q4.size() == 4 && done_mismatch4 !== any_mis(q4))) begin
        errors++;
        $display("FAIL rand4 cyc%0d got cnt=%0d dv=%0b rdy=%0b mm=%0b last=%h want cnt=%0d mm=%0b last=%h",
                 i, count4, done_valid4, ins_ready4, done_mismatch4, last_value4,
                 q4.size(), any_mis(q4), last4);
      end
      checks++;
      if (count1 !== 8'(q1.size()) || done_valid1 !== (q1.size() == 1) ||
          ins_ready1 !== (q1.size() != 1) || last_value1 !== last1 ||
          (q1.size() == 1 && done_mismatch1 !== any_mis(q1))) begin
        errors++;
        $display("FAIL rand1 cyc%0d got cnt=%0d dv=%0b rdy=%0b mm=%0b last=%h want cnt=%0d mm=%0b last=%h",
                 i, count1, done_valid1, ins_ready1, done_mismatch1, last_value1,
                 q1.size(), any_mis(q1), last1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_batch();
    test_mismatch_batch();
    test_done_stall();
    test_single_token();
    test_reset_mid_batch();
    test_reset_in_done();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
